// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from ID/EX/MEM plus register-control outputs.
// Combinational interface only; no storage of its own.
// No backpressure; the controller answers every cycle.
//
// Modports:
//   master - pipeline side: drives hazard inputs, receives stall/bubble/flush controls
//   slave  - controller side: the mirror image of master
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_br_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              err_clr;

    logic              pc_stall;
    logic              if_id_stall;
    logic              id_ex_stall;
    logic              ex_mem_stall;
    logic              id_ex_bubble;
    logic              mem_wb_bubble;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mem_timeout_err;
    logic [1:0]        state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_br_taken, mem_req, mem_ready, err_clr,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               mem_wb_bubble, if_id_flush, id_ex_flush, mem_timeout_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_br_taken, mem_req, mem_ready, err_clr,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               mem_wb_bubble, if_id_flush, id_ex_flush, mem_timeout_err, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, branch squash, dmem freeze.
// Zero latency: every control output is combinational from state and current inputs.
// Freezes all stages while a dmem access is outstanding, bounded by MEM_TIMEOUT cycles.
//
// Ports: clk, rst_n (async active-low); hz (slave modport) carries the hazard inputs
// and the stage-register controls. Optional macro HAZ_PERF_CNT_EN adds the saturating
// counters stall_cycles[31:0] (cycles with any stall) and flush_count[15:0] (if_id_flush cycles).
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    localparam logic [REG_AW-1:0] X0      = '0;
    localparam logic [CNT_W-1:0]  TMO_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             err_q, err_d;
    logic             tmo_set;

    logic             load_use;
    logic             mem_hold;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = hz.ex_memread && (hz.ex_rd != X0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    assign mem_hold = hz.mem_req && !hz.mem_ready;

    always_comb begin
        hz.pc_stall      = 1'b0;
        hz.if_id_stall   = 1'b0;
        hz.id_ex_stall   = 1'b0;
        hz.ex_mem_stall  = 1'b0;
        hz.id_ex_bubble  = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        state_d          = state_q;
        tmo_cnt_d        = '0;
        flush_pend_d     = flush_pend_q;
        tmo_set          = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_hold) begin
                    hz.pc_stall      = 1'b1;
                    hz.if_id_stall   = 1'b1;
                    hz.id_ex_stall   = 1'b1;
                    hz.ex_mem_stall  = 1'b1;
                    hz.mem_wb_bubble = 1'b1;
                    state_d          = MEM_WAIT;
                    tmo_cnt_d        = CNT_W'(1);
                    // The branch is frozen in EX; squash once memory releases.
                    if (hz.ex_br_taken) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (hz.ex_br_taken) begin
                    // ID holds a wrong-path instruction, so any load-use match is moot.
                    hz.if_id_flush = 1'b1;
                    hz.id_ex_flush = 1'b1;
                end else if (load_use) begin
                    hz.pc_stall     = 1'b1;
                    hz.if_id_stall  = 1'b1;
                    hz.id_ex_bubble = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (hz.ex_br_taken) begin
                    flush_pend_d = 1'b1;
                end
                if (hz.mem_ready || (tmo_cnt_q == TMO_MAX)) begin
                    // Release: either the access completed or it gave up.
                    tmo_set = !hz.mem_ready;
                    state_d = (flush_pend_q || hz.ex_br_taken) ? FLUSH : RUN;
                end else begin
                    hz.pc_stall      = 1'b1;
                    hz.if_id_stall   = 1'b1;
                    hz.id_ex_stall   = 1'b1;
                    hz.ex_mem_stall  = 1'b1;
                    hz.mem_wb_bubble = 1'b1;
                    tmo_cnt_d        = tmo_cnt_q + CNT_W'(1);
                end
            end

            FLUSH: begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
                flush_pend_d   = 1'b0;
                state_d        = RUN;
            end

            default: begin
                state_d      = RUN;
                flush_pend_d = 1'b0;
            end
        endcase

        // A new timeout outranks a simultaneous clear request.
        if (tmo_set) begin
            err_d = 1'b1;
        end else if (hz.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            tmo_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

    assign hz.mem_timeout_err = err_q;
    assign hz.state           = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if ((hz.pc_stall || hz.if_id_stall || hz.id_ex_stall || hz.ex_mem_stall) &&
                (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (hz.if_id_flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then random traffic.
// Expectations come from a cycle-level behavioural model of the hazard rules.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: which phase the pipeline is in, how many wait cycles have
    // already elapsed, whether a squash is owed, and the sticky error.
    int          m_phase;    // 0 running, 1 waiting on dmem, 2 squash cycle
    int          m_waited;
    bit          m_owe_squash;
    bit          m_err;
    longint      m_stalls;
    longint      m_flushes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_waited     = 0;
        m_owe_squash = 0;
        m_err        = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    function automatic bit reads_reg(input logic use_bit, input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return use_bit && (src == dst);
    endfunction

    // Checks the current cycle's outputs against the model, then advances the model
    // to what the next cycle should look like.
    task automatic eval_cycle(input string tag);
        bit dmem_busy, hazard, frozen, squash, lu_stall, gave_up, done_wait;
        int next_phase;
        logic [7:0] exp_ctl, obs_ctl;

        dmem_busy = hz.mem_req && !hz.mem_ready;
        hazard    = hz.ex_memread && (hz.ex_rd != 0) &&
                    (reads_reg(hz.id_use_rs1, hz.id_rs1, hz.ex_rd) ||
                     reads_reg(hz.id_use_rs2, hz.id_rs2, hz.ex_rd));
        frozen = 0; squash = 0; lu_stall = 0; gave_up = 0; next_phase = 0;

        if (m_phase == 0) begin
            frozen     = dmem_busy;
            squash     = !dmem_busy && hz.ex_br_taken;
            lu_stall   = !dmem_busy && !hz.ex_br_taken && hazard;
            next_phase = dmem_busy ? 1 : 0;
        end else if (m_phase == 1) begin
            gave_up    = !hz.mem_ready && (m_waited + 1 == MEM_TIMEOUT);
            done_wait  = hz.mem_ready || gave_up;
            frozen     = !done_wait;
            next_phase = !done_wait ? 1 : ((m_owe_squash || hz.ex_br_taken) ? 2 : 0);
        end else begin
            squash     = 1;
            next_phase = 0;
        end

        exp_ctl = {frozen | lu_stall, frozen | lu_stall, frozen, frozen,
                   lu_stall, frozen, squash, squash};
        obs_ctl = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall,
                   hz.id_ex_bubble, hz.mem_wb_bubble, hz.if_id_flush, hz.id_ex_flush};
        check({tag, ".ctl"},   32'(obs_ctl), 32'(exp_ctl));
        check({tag, ".state"}, 32'(hz.state), 32'(m_phase));
        check({tag, ".err"},   32'(hz.mem_timeout_err), 32'(m_err));
`ifdef HAZ_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cycles, 32'(m_stalls));
        check({tag, ".flush_cnt"}, 32'(flush_count), 32'(m_flushes));
`endif

        if (rst_n) begin
            if ((m_phase == 0 && dmem_busy && hz.ex_br_taken) || (m_phase == 1 && hz.ex_br_taken))
                m_owe_squash = 1;
            if (m_phase == 2)
                m_owe_squash = 0;
            m_waited  = (next_phase == 1 && m_phase == 1) ? m_waited + 1 : 0;
            m_err     = gave_up ? 1'b1 : (hz.err_clr ? 1'b0 : m_err);
            m_stalls  = m_stalls + ((frozen || lu_stall) ? 1 : 0);
            m_flushes = m_flushes + (squash ? 1 : 0);
            m_phase   = next_phase;
        end
    endtask

    task automatic cyc(input string tag,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req,
                       input logic rdy, input logic clr);
        @(negedge clk);
        hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
        hz.ex_rd = rd; hz.ex_memread = mr; hz.ex_br_taken = br;
        hz.mem_req = req; hz.mem_ready = rdy; hz.err_clr = clr;
        #1;
        eval_cycle(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Watchdog: the sequence below is bounded, so this only fires if something stalls time.
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
        hz.ex_rd = '0; hz.ex_memread = 1'b0; hz.ex_br_taken = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.err_clr = 1'b0;
        model_reset();

        // Reset state, checked while reset is held.
        idle("reset");
        check("reset.pc_stall", 32'(hz.pc_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw x5 in EX, ID reads x5 via rs2: one stall cycle, then clear.
        cyc("lu", 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu.bubble", 32'({hz.pc_stall, hz.if_id_stall, hz.id_ex_bubble}), 32'h7);
        cyc("lu_after", 5'd1, 5'd5, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_after.pc_stall", 32'(hz.pc_stall), 32'd0);

        // Load into x0 never stalls.
        cyc("x0", 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("x0.pc_stall", 32'(hz.pc_stall), 32'd0);

        // Taken branch beats load-use.
        cyc("br_lu", 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("br_lu.flush", 32'({hz.if_id_flush, hz.id_ex_flush, hz.pc_stall}), 32'h6);
        idle("br_lu_after");

        // Ready low for three cycles, high on the fourth.
        for (int i = 0; i < 3; i++)
            cyc("frz", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("frz_rel", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("frz_rel.ex_mem_stall", 32'(hz.ex_mem_stall), 32'd0);
        idle("frz_after");

        // Hold with a taken branch: RUN, MW, MW, FLUSH, RUN.
        cyc("hb0", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("hb0.noflush", 32'(hz.if_id_flush), 32'd0);
        cyc("hb1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("hb2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("hb2.state", 32'(hz.state), 32'd1);
        idle("hb3");
        check("hb3.flush", 32'({hz.state, hz.if_id_flush, hz.id_ex_flush}), 32'hB);
        idle("hb4");
        check("hb4.state", 32'(hz.state), 32'd0);

        // Memory never answers: timeout after 16 wait cycles, error sticks until cleared.
        for (int i = 0; i < MEM_TIMEOUT; i++)
            cyc("tmo", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("tmo_last", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("tmo_last.release", 32'({hz.pc_stall, hz.mem_timeout_err}), 32'd0);
        for (int i = 0; i < 3; i++)
            idle("tmo_sticky");
        check("tmo_sticky.err", 32'(hz.mem_timeout_err), 32'd1);
        cyc("tmo_clr", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("tmo_cleared");
        check("tmo_cleared.err", 32'(hz.mem_timeout_err), 32'd0);

        // Async reset in the middle of a wait with a squash owed.
        cyc("ar0", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ar1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        hz.mem_req = 1'b0; hz.ex_br_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst.state", 32'(hz.state), 32'd0);
        check("arst.stalls", 32'({hz.pc_stall, hz.ex_mem_stall, hz.mem_wb_bubble}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle("arst_after");
        check("arst_after.noflush", 32'(hz.if_id_flush), 32'd0);

        // Random traffic; register indices drawn from a small range to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            cyc("rnd",
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2),
                1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 4),
                1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
